// File: rtl/fetch_fifo.sv
// fetch_fifo: four-entry instruction fetch FIFO between the instruction-memory
// response path and the decoder of the RISC-V prefetch buffer.
//
// Stores fetched 32-bit words with their addresses. When empty, the incoming
// word is bypassed combinationally to the output. Realigns 16/32-bit
// instructions, including 32-bit instructions straddling two words, and
// supports hardware-loop redirection by replacing the second entry.
//
// Ports:
//   clk, rst_n                 clock; synchronous active-high reset
//   clear_i                    flush all valid / hwloop flags
//   in_addr_i, in_rdata_i      incoming word and its address
//   in_valid_i, in_ready_o     input handshake
//   in_replace2_i              incoming word replaces entry 1 (hwloop target)
//   in_is_hwlp_i               incoming word is a hwloop target
//   out_valid_o, out_ready_i   output handshake
//   out_rdata_o, out_addr_o    realigned instruction and its address
//   out_valid_stored_o         instruction after the current one is stored
//   unaligned_is_compressed_o  upper halfword of the head word is compressed
//   out_is_hwlp_o              current instruction is a hwloop target
module fetch_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear_i,
  input  logic [31:0] in_addr_i,
  input  logic [31:0] in_rdata_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic        in_replace2_i,
  input  logic        in_is_hwlp_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_rdata_o,
  output logic [31:0] out_addr_o,
  output logic        out_valid_stored_o,
  output logic        unaligned_is_compressed_o,
  output logic        out_is_hwlp_o
);

  logic [31:0]      addr_q  [DEPTH];
  logic [31:0]      addr_int[DEPTH];
  logic [31:0]      addr_n  [DEPTH];
  logic [31:0]      rdata_q  [DEPTH];
  logic [31:0]      rdata_int[DEPTH];
  logic [31:0]      rdata_n  [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_int, valid_n;
  logic [DEPTH-1:0] is_hwlp_q, is_hwlp_int, is_hwlp_n;

  logic [31:0] rdata, rdata_unaligned, next_word;
  logic        valid, valid_unaligned;
  logic        aligned_is_compressed, unaligned_is_compressed;
  logic        use_unaligned;
  logic [31:2] addr_next;
  logic        found;

  assign rdata           = valid_q[0] ? rdata_q[0] : in_rdata_i;
  assign valid           = valid_q[0] | in_valid_i | is_hwlp_q[1];
  assign next_word       = valid_q[1] ? rdata_q[1] : in_rdata_i;
  assign rdata_unaligned = {next_word[15:0], rdata[31:16]};
  assign valid_unaligned = valid_q[1] | (valid_q[0] & in_valid_i);

  assign unaligned_is_compressed = (rdata[17:16] != 2'b11);
  assign aligned_is_compressed   = (rdata[1:0]   != 2'b11);
  assign unaligned_is_compressed_o = unaligned_is_compressed;

  assign out_addr_o    = valid_q[0] ? addr_q[0]    : in_addr_i;
  assign out_is_hwlp_o = valid_q[0] ? is_hwlp_q[0] : in_is_hwlp_i;

  // A pending hwloop target in entry 1 overrides realignment of the head.
  assign use_unaligned = out_addr_o[1] & ~is_hwlp_q[1];

  always_comb begin
    if (use_unaligned) begin
      out_rdata_o        = rdata_unaligned;
      out_valid_o        = unaligned_is_compressed ? valid : valid_unaligned;
      out_valid_stored_o = unaligned_is_compressed ? 1'b1  : valid_q[2];
    end else begin
      out_rdata_o        = rdata;
      out_valid_o        = valid;
      out_valid_stored_o = valid_q[1];
    end
  end

  assign in_ready_o = ~valid_q[DEPTH-2];

  // Push stage
  always_comb begin
    addr_int    = addr_q;
    rdata_int   = rdata_q;
    valid_int   = valid_q;
    is_hwlp_int = is_hwlp_q;
    found       = 1'b0;

    if (in_valid_i) begin
      for (int unsigned j = 0; j < DEPTH; j++) begin
        if (!found && !valid_q[j]) begin
          addr_int[j]    = in_addr_i;
          rdata_int[j]   = in_rdata_i;
          valid_int[j]   = 1'b1;
          is_hwlp_int[j] = in_is_hwlp_i;
          found          = 1'b1;
        end
      end

      if (in_replace2_i) begin
        if (valid_q[0]) begin
          // Keep the realigned head in slot 0 so a straddling instruction
          // survives the loss of the words behind it.
          addr_int[1]    = in_addr_i;
          rdata_int[0]   = out_rdata_o;
          rdata_int[1]   = in_rdata_i;
          valid_int[1]   = 1'b1;
          is_hwlp_int[1] = in_is_hwlp_i;
          for (int unsigned j = 2; j < DEPTH; j++) begin
            valid_int[j] = 1'b0;
          end
        end else begin
          is_hwlp_int[0] = in_is_hwlp_i;
        end
      end
    end
  end

  assign addr_next = addr_int[0][31:2] + 30'd1;

  // Pop stage, applied on top of the push result
  always_comb begin
    addr_n    = addr_int;
    rdata_n   = rdata_int;
    valid_n   = valid_int;
    is_hwlp_n = is_hwlp_int;

    if (out_valid_o && out_ready_i) begin
      is_hwlp_n = {1'b0, is_hwlp_int[DEPTH-1:1]};

      if (is_hwlp_int[1]) begin
        addr_n[0] = addr_int[1];
        for (int unsigned i = 0; i < DEPTH - 1; i++) begin
          rdata_n[i] = rdata_int[i+1];
        end
        rdata_n[DEPTH-1] = '0;
        valid_n          = {1'b0, valid_int[DEPTH-1:1]};
      end else if (addr_int[0][1]) begin
        addr_n[0] = {addr_next, unaligned_is_compressed ? 2'b00 : 2'b10};
        for (int unsigned i = 0; i < DEPTH - 1; i++) begin
          rdata_n[i] = rdata_int[i+1];
        end
        rdata_n[DEPTH-1] = '0;
        valid_n          = {1'b0, valid_int[DEPTH-1:1]};
      end else if (aligned_is_compressed) begin
        addr_n[0] = {addr_int[0][31:2], 2'b10};
      end else begin
        addr_n[0] = {addr_next, 2'b00};
        for (int unsigned i = 0; i < DEPTH - 1; i++) begin
          rdata_n[i] = rdata_int[i+1];
        end
        rdata_n[DEPTH-1] = '0;
        valid_n          = {1'b0, valid_int[DEPTH-1:1]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        addr_q[i]  <= '0;
        rdata_q[i] <= '0;
      end
      valid_q   <= '0;
      is_hwlp_q <= '0;
    end else begin
      addr_q  <= addr_n;
      rdata_q <= rdata_n;
      if (clear_i) begin
        valid_q   <= '0;
        is_hwlp_q <= '0;
      end else begin
        valid_q   <= valid_n;
        is_hwlp_q <= is_hwlp_n;
      end
    end
  end

endmodule

// File: tb/tb_fetch_fifo.sv
// tb_fetch_fifo: directed-vector bench for fetch_fifo with hand-computed
// expected values.
module tb_fetch_fifo;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear_i;
  logic [31:0] in_addr_i;
  logic [31:0] in_rdata_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic        in_replace2_i;
  logic        in_is_hwlp_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_rdata_o;
  logic [31:0] out_addr_o;
  logic        out_valid_stored_o;
  logic        unaligned_is_compressed_o;
  logic        out_is_hwlp_o;

  int vectors     = 0;
  int miscompares = 0;

  fetch_fifo #(.DEPTH(4)) dut (
    .clk                       (clk),
    .rst_n                     (rst_n),
    .clear_i                   (clear_i),
    .in_addr_i                 (in_addr_i),
    .in_rdata_i                (in_rdata_i),
    .in_valid_i                (in_valid_i),
    .in_ready_o                (in_ready_o),
    .in_replace2_i             (in_replace2_i),
    .in_is_hwlp_i              (in_is_hwlp_i),
    .out_valid_o               (out_valid_o),
    .out_ready_i               (out_ready_i),
    .out_rdata_o               (out_rdata_o),
    .out_addr_o                (out_addr_o),
    .out_valid_stored_o        (out_valid_stored_o),
    .unaligned_is_compressed_o (unaligned_is_compressed_o),
    .out_is_hwlp_o             (out_is_hwlp_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d,
                       input logic rdy);
    in_valid_i    = v;
    in_addr_i     = a;
    in_rdata_i    = d;
    out_ready_i   = rdy;
    in_replace2_i = 1'b0;
    in_is_hwlp_i  = 1'b0;
    clear_i       = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b1;
    drive(1'b0, '0, '0, 1'b0);
    next_cycle();
    next_cycle();
    rst_n = 1'b0;

    // Reset state with idle inputs: bypass shows input address/hwlp flag
    drive(1'b0, 32'h0000_0ABC, '0, 1'b0);
    in_is_hwlp_i = 1'b1;
    #3;
    check("rst_valid",  32'(out_valid_o),        32'd0);
    check("rst_ready",  32'(in_ready_o),         32'd1);
    check("rst_stored", 32'(out_valid_stored_o), 32'd0);
    check("rst_addr",   out_addr_o,              32'h0000_0ABC);
    check("rst_hwlp",   32'(out_is_hwlp_o),      32'd1);
    next_cycle();

    // Bypass of a 32-bit word, popped in the same cycle
    drive(1'b1, 32'h100, 32'h0000_0013, 1'b1);
    #3;
    check("t1_valid", 32'(out_valid_o), 32'd1);
    check("t1_addr",  out_addr_o,       32'h100);
    check("t1_rdata", out_rdata_o,      32'h0000_0013);
    next_cycle();
    drive(1'b0, '0, '0, 1'b0);
    #3;
    check("t1_empty", 32'(out_valid_o), 32'd0);
    check("t1_ready", 32'(in_ready_o),  32'd1);
    next_cycle();

    // Two compressed instructions in one word
    drive(1'b1, 32'h200, 32'h4501_4501, 1'b1);
    #3;
    check("t2_valid0", 32'(out_valid_o), 32'd1);
    check("t2_addr0",  out_addr_o,       32'h200);
    next_cycle();
    drive(1'b0, '0, '0, 1'b1);
    #3;
    check("t2_addr1",   out_addr_o,                     32'h202);
    check("t2_rdata1",  out_rdata_o,                    32'h0000_4501);
    check("t2_stored1", 32'(out_valid_stored_o),        32'd1);
    check("t2_uc1",     32'(unaligned_is_compressed_o), 32'd1);
    next_cycle();
    drive(1'b0, '0, '0, 1'b0);
    #3;
    check("t2_empty", 32'(out_valid_o), 32'd0);
    next_cycle();

    // 32-bit instruction straddling two words
    drive(1'b1, 32'h100, 32'hAAAB_0001, 1'b1);
    #3;
    check("t3_head", out_rdata_o, 32'hAAAB_0001);
    next_cycle();
    drive(1'b0, '0, '0, 1'b0);
    #3;
    check("t3_addr", out_addr_o,                     32'h102);
    check("t3_wait", 32'(out_valid_o),               32'd0);
    check("t3_uc",   32'(unaligned_is_compressed_o), 32'd0);
    next_cycle();
    drive(1'b1, 32'h104, 32'h1234_5678, 1'b0);
    #3;
    check("t3_join_valid", 32'(out_valid_o), 32'd1);
    check("t3_join_rdata", out_rdata_o,      32'h5678_AAAB);
    next_cycle();
    drive(1'b0, '0, '0, 1'b1);
    #3;
    check("t3_st_valid",  32'(out_valid_o),        32'd1);
    check("t3_st_rdata",  out_rdata_o,             32'h5678_AAAB);
    check("t3_st_stored", 32'(out_valid_stored_o), 32'd0);
    next_cycle();
    #3;
    check("t3_addr2",  out_addr_o,       32'h106);
    check("t3_rdata2", out_rdata_o,      32'h0000_1234);
    check("t3_valid2", 32'(out_valid_o), 32'd1);
    next_cycle();
    drive(1'b0, '0, '0, 1'b0);
    #3;
    check("t3_empty", 32'(out_valid_o), 32'd0);
    next_cycle();

    // Fill to the ready threshold, then drain
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h300 + 32'(4 * i), 32'h0000_0013, 1'b0);
      #3;
      check("t4_ready_fill", 32'(in_ready_o), 32'd1);
      next_cycle();
    end
    drive(1'b0, '0, '0, 1'b0);
    #3;
    check("t4_full",   32'(in_ready_o),         32'd0);
    check("t4_stored", 32'(out_valid_stored_o), 32'd1);
    next_cycle();
    drive(1'b0, '0, '0, 1'b1);
    #3;
    check("t4_addr0", out_addr_o, 32'h300);
    next_cycle();
    #3;
    check("t4_ready_pop", 32'(in_ready_o), 32'd1);
    check("t4_addr1",     out_addr_o,      32'h304);
    next_cycle();
    #3;
    check("t4_addr2", out_addr_o, 32'h308);
    next_cycle();
    drive(1'b0, '0, '0, 1'b0);
    #3;
    check("t4_empty", 32'(out_valid_o), 32'd0);
    next_cycle();

    // Four words then flush
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h600 + 32'(4 * i), 32'h0000_0013, 1'b0);
      next_cycle();
    end
    drive(1'b0, '0, '0, 1'b0);
    #3;
    check("t5_full_ready", 32'(in_ready_o),  32'd0);
    check("t5_full_valid", 32'(out_valid_o), 32'd1);
    clear_i = 1'b1;
    next_cycle();
    drive(1'b0, '0, '0, 1'b0);
    #3;
    check("t5_clr_valid",  32'(out_valid_o),        32'd0);
    check("t5_clr_ready",  32'(in_ready_o),         32'd1);
    check("t5_clr_stored", 32'(out_valid_stored_o), 32'd0);
    next_cycle();

    // Hardware-loop redirection replacing entry 1
    drive(1'b1, 32'h500, 32'h0000_0013, 1'b0);
    next_cycle();
    drive(1'b1, 32'h504, 32'h0000_0013, 1'b0);
    next_cycle();
    drive(1'b1, 32'h400, 32'h0000_0093, 1'b0);
    in_replace2_i = 1'b1;
    in_is_hwlp_i  = 1'b1;
    next_cycle();
    drive(1'b0, '0, '0, 1'b1);
    #3;
    check("t6_head_addr", out_addr_o,              32'h500);
    check("t6_head_hwlp", 32'(out_is_hwlp_o),      32'd0);
    check("t6_stored",    32'(out_valid_stored_o), 32'd1);
    check("t6_ready",     32'(in_ready_o),         32'd1);
    next_cycle();
    drive(1'b0, '0, '0, 1'b0);
    #3;
    check("t6_addr",  out_addr_o,         32'h400);
    check("t6_hwlp",  32'(out_is_hwlp_o), 32'd1);
    check("t6_rdata", out_rdata_o,        32'h0000_0093);
    check("t6_valid", 32'(out_valid_o),   32'd1);
    next_cycle();
    drive(1'b0, '0, '0, 1'b1);
    next_cycle();
    drive(1'b0, '0, '0, 1'b0);
    #3;
    check("t6_empty",    32'(out_valid_o),   32'd0);
    check("t6_hwlp_clr", 32'(out_is_hwlp_o), 32'd0);
    next_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
